// File: rtl/fetch_controller_if.sv
// Instruction-memory request/ack bus between the fetch controller and memory.
interface fetch_controller_if #(
   parameter int unsigned N = 32
);
   logic         mem_req;
   logic [N-1:0] mem_addr;
   logic         mem_ack;
   logic [N-1:0] mem_rdata;

   modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
   modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: 2-entry fetch FIFO, branch redirect with drop of stale acks.
// Optional feature macro FETCH_TIMEOUT_EN adds a sticky memory wait-timeout flag.
module fetch_controller #(
   parameter int unsigned  N        = 32,
   parameter logic [N-1:0] RESET_PC = '0,
   parameter int unsigned  TIMEOUT  = 15
) (
   input  logic                clk,
   input  logic                rst,
   fetch_controller_if.master  mem,
   input  logic                freeze,
   input  logic                branch_taken,
   input  logic [N-1:0]        branch_addr,
   output logic                valid,
   output logic [N-1:0]        instruction,
   output logic [N-1:0]        pc_out,
   output logic                flush,
   output logic                timeout
);

   typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

   state_t       state;
   logic [N-1:0] pc;
   logic [N-1:0] req_addr;
   logic         mem_req;
   logic         drop;
   logic [1:0]   count;
   logic [N-1:0] e0_instr, e0_pcp4;
   logic [N-1:0] e1_instr, e1_pcp4;

   logic [N-1:0] target;
   logic [N-1:0] next_addr;
   logic         ack;
   logic         consume;
   logic         push;
   logic [1:0]   occ;
   logic [1:0]   count_nxt;
   logic         unused_addr_lsbs;

   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("fetch_controller: TIMEOUT must be at least 1");
   end

   assign target           = {branch_addr[N-1:2], 2'b00};
   assign unused_addr_lsbs = ^branch_addr[1:0];
   assign next_addr        = req_addr + N'(4);
   assign ack              = mem_req & mem.mem_ack;
   assign consume          = valid & ~freeze & ~branch_taken;
   assign push             = ack & ~drop & ~branch_taken;
   assign occ              = count - 2'(consume);

   assign mem.mem_req  = mem_req;
   assign mem.mem_addr = req_addr;
   assign instruction  = e0_instr;
   assign pc_out       = e0_pcp4;

   // Occupancy after this edge; a branch empties the queue.
   always_comb begin
      count_nxt = count;
      if (branch_taken) count_nxt = 2'd0;
      else              count_nxt = occ + 2'(push);
   end

   // FIFO, fetch FSM and redirect handling.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         mem_req  <= 1'b0;
         drop     <= 1'b0;
         count    <= 2'd0;
         valid    <= 1'b0;
         flush    <= 1'b0;
         e0_instr <= '0;
         e0_pcp4  <= '0;
         e1_instr <= '0;
         e1_pcp4  <= '0;
      end else begin
         flush <= branch_taken;
         count <= count_nxt;
         valid <= (count_nxt != 2'd0);

         if (consume) begin
            e0_instr <= e1_instr;
            e0_pcp4  <= e1_pcp4;
         end
         // New word lands in the first free slot after any concurrent pop.
         if (push) begin
            if (occ == 2'd0) begin
               e0_instr <= mem.mem_rdata;
               e0_pcp4  <= next_addr;
            end else begin
               e1_instr <= mem.mem_rdata;
               e1_pcp4  <= next_addr;
            end
         end

         case (state)
            IDLE: begin
               state   <= REQ;
               mem_req <= 1'b1;
               if (branch_taken) begin
                  pc       <= target;
                  req_addr <= target;
               end else begin
                  req_addr <= pc;
               end
            end
            REQ: begin
               if (ack) begin
                  drop <= 1'b0;
                  if (branch_taken) begin
                     pc       <= target;
                     req_addr <= target;
                  end else if (drop) begin
                     req_addr <= pc;
                  end else begin
                     pc <= next_addr;
                     if (count_nxt == 2'd2) begin
                        state   <= FULL;
                        mem_req <= 1'b0;
                     end else begin
                        req_addr <= next_addr;
                     end
                  end
               end else if (branch_taken) begin
                  // Request stays on the bus; its ack will be thrown away.
                  drop <= 1'b1;
                  pc   <= target;
               end
            end
            FULL: begin
               if (branch_taken) begin
                  state    <= REQ;
                  mem_req  <= 1'b1;
                  pc       <= target;
                  req_addr <= target;
               end else if (consume) begin
                  state    <= REQ;
                  mem_req  <= 1'b1;
                  req_addr <= pc;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned WW = $clog2(TIMEOUT + 1);

   logic [WW-1:0] wait_cnt;
   logic          timeout_q;

   // Consecutive unanswered request cycles; flag is sticky until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else if (mem_req && !mem.mem_ack) begin
         if (wait_cnt != WW'(TIMEOUT)) wait_cnt <= wait_cnt + WW'(1);
         if (wait_cnt == WW'(TIMEOUT - 1)) timeout_q <= 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule
